// File: rtl/pkg_smartcargo.sv
// Shared types for the request queue: floor numbers, queued stops and insertion FSM states.
package pkg_smartcargo;

    localparam int ANDAR_W = 2;

    typedef logic [ANDAR_W-1:0] andar_t;

    typedef struct packed {
        logic   eh_origem;
        andar_t andar;
    } parada_t;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        GRAVA_ORIGEM  = 2'd1,
        GRAVA_DESTINO = 2'd2
    } estado_t;

endpackage

// File: rtl/fifo_paradas.sv
// Circular buffer of stops with occupancy count; pop on empty is ignored, clear flushes.
module fifo_paradas
    import pkg_smartcargo::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic [ANDAR_W:0]   din,
    input  logic               pop,
    output logic [ANDAR_W:0]   head,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    parada_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop_ok;

    assign pop_ok = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop_ok)      count_d = count_q + CNT_W'(1);
            else if (!push && pop_ok) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr_q] <= parada_t'(din);
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fila_pedidos.sv
// Request queue in front of the movement FSM: splits each request into pickup/drop-off stops.
//   state         | meaning
//   OCIOSO        | waiting for a request; validates origin != destination
//   GRAVA_ORIGEM  | writing the pickup stop
//   GRAVA_DESTINO | writing the drop-off stop
module fila_pedidos
    import pkg_smartcargo::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               pedido_valid,
    output logic               pedido_ready,
    input  logic [ANDAR_W-1:0] pedido_origem,
    input  logic [ANDAR_W-1:0] pedido_destino,
    output logic               pedido_invalido,
    input  logic               shift,
    input  logic [ANDAR_W-1:0] andar_atual,
    output logic [ANDAR_W-1:0] destino_atual,
    output logic               temDestino,
    output logic               eh_origem,
    output logic               sobe,
    output logic               chegouDestino,
    output logic [CNT_W-1:0]   ocupacao,
    output logic [1:0]         db_estado
);
    estado_t          estado_q, estado_d;
    andar_t           origem_q, origem_d;
    andar_t           destino_q, destino_d;
    logic             invalido_q, invalido_d;
    logic             push;
    parada_t          din;
    parada_t          head;
    logic [CNT_W-1:0] count;
    logic             espaco;

    // Two free slots are reserved up front so the second write can never overflow.
    assign espaco = (count <= CNT_W'(DEPTH - 2));

    always_comb begin
        estado_d     = estado_q;
        origem_d     = origem_q;
        destino_d    = destino_q;
        invalido_d   = 1'b0;
        push         = 1'b0;
        din          = '0;
        pedido_ready = 1'b0;
        case (estado_q)
            OCIOSO: begin
                pedido_ready = espaco;
                if (pedido_valid && espaco) begin
                    origem_d  = pedido_origem;
                    destino_d = pedido_destino;
                    if (pedido_origem == pedido_destino) invalido_d = 1'b1;
                    else                                 estado_d   = GRAVA_ORIGEM;
                end
            end
            GRAVA_ORIGEM: begin
                push     = 1'b1;
                din      = '{eh_origem: 1'b1, andar: origem_q};
                estado_d = GRAVA_DESTINO;
            end
            GRAVA_DESTINO: begin
                push     = 1'b1;
                din      = '{eh_origem: 1'b0, andar: destino_q};
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
        if (clear) begin
            estado_d   = OCIOSO;
            invalido_d = 1'b0;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            origem_q   <= '0;
            destino_q  <= '0;
            invalido_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            origem_q   <= origem_d;
            destino_q  <= destino_d;
            invalido_q <= invalido_d;
        end
    end

    fifo_paradas #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .din   (din),
        .pop   (shift),
        .head  (head),
        .count (count)
    );

    assign temDestino      = (count != '0);
    assign destino_atual   = temDestino ? head.andar : '0;
    assign eh_origem       = temDestino && head.eh_origem;
    assign sobe            = temDestino && (destino_atual > andar_atual);
    assign chegouDestino   = temDestino && (destino_atual == andar_atual);
    assign ocupacao        = count;
    assign db_estado       = estado_q;
    assign pedido_invalido = invalido_q;

endmodule

// File: tb/tb_fila_pedidos.sv
// Directed bench for fila_pedidos: vector table plus hand-written multi-cycle sequences.
module tb_fila_pedidos;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       pedido_valid = 1'b0;
    logic       pedido_ready;
    logic [1:0] pedido_origem = '0;
    logic [1:0] pedido_destino = '0;
    logic       pedido_invalido;
    logic       shift = 1'b0;
    logic [1:0] andar_atual = '0;
    logic [1:0] destino_atual;
    logic       temDestino;
    logic       eh_origem;
    logic       sobe;
    logic       chegouDestino;
    logic [3:0] ocupacao;
    logic [1:0] db_estado;

    int passed = 0;
    int total  = 0;

    fila_pedidos #(.DEPTH(8), .CNT_W(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .clear           (clear),
        .pedido_valid    (pedido_valid),
        .pedido_ready    (pedido_ready),
        .pedido_origem   (pedido_origem),
        .pedido_destino  (pedido_destino),
        .pedido_invalido (pedido_invalido),
        .shift           (shift),
        .andar_atual     (andar_atual),
        .destino_atual   (destino_atual),
        .temDestino      (temDestino),
        .eh_origem       (eh_origem),
        .sobe            (sobe),
        .chegouDestino   (chegouDestino),
        .ocupacao        (ocupacao),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       valid;
        logic [1:0] orig;
        logic [1:0] dest;
        logic       shf;
        logic [1:0] andar;
        logic       e_tem;
        logic [1:0] e_dest;
        logic       e_eh;
        logic       e_sobe;
        logic       e_cheg;
        logic [3:0] e_ocup;
        logic       e_ready;
        logic       e_inv;
        logic [1:0] e_est;
    } vec_t;

    vec_t tab [8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pedido(input logic [1:0] o, input logic [1:0] d);
        pedido_origem  = o;
        pedido_destino = d;
        pedido_valid   = 1'b1;
        step();
        pedido_valid   = 1'b0;
        step();
        step();
    endtask

    task automatic chk_head(input string nm, input int tem, input int dest, input int eh);
        chk({nm, ".tem"}, temDestino, tem);
        chk({nm, ".dest"}, destino_atual, dest);
        chk({nm, ".eh"}, eh_origem, eh);
    endtask

    int exp_floor [7] = '{2, 2, 3, 3, 0, 3, 1};
    int exp_eh    [7] = '{0, 1, 0, 1, 0, 1, 0};

    initial begin
        //         vld o  d  shf and  tem dst eh sobe chg ocup rdy inv est
        tab[0] = '{1, 0, 3, 0,  0,   0,  0,  0, 0,   0,  0,   0,  0,  1};
        tab[1] = '{0, 0, 0, 0,  0,   1,  0,  1, 0,   1,  1,   0,  0,  2};
        tab[2] = '{0, 0, 0, 0,  0,   1,  0,  1, 0,   1,  2,   1,  0,  0};
        tab[3] = '{0, 0, 0, 1,  0,   1,  3,  0, 1,   0,  1,   1,  0,  0};
        tab[4] = '{0, 0, 0, 1,  0,   0,  0,  0, 0,   0,  0,   1,  0,  0};
        tab[5] = '{1, 2, 2, 0,  0,   0,  0,  0, 0,   0,  0,   1,  1,  0};
        tab[6] = '{0, 0, 0, 0,  0,   0,  0,  0, 0,   0,  0,   1,  0,  0};
        tab[7] = '{0, 0, 0, 1,  2,   0,  0,  0, 0,   0,  0,   1,  0,  0};

        #2;
        chk("rst.tem", temDestino, 0);
        chk("rst.ready", pedido_ready, 1);
        chk("rst.ocup", ocupacao, 0);
        chk("rst.estado", db_estado, 0);
        chk("rst.inv", pedido_invalido, 0);
        #10 reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            pedido_valid   = tab[i].valid;
            pedido_origem  = tab[i].orig;
            pedido_destino = tab[i].dest;
            shift          = tab[i].shf;
            andar_atual    = tab[i].andar;
            step();
            chk($sformatf("v%0d.tem", i), temDestino, tab[i].e_tem);
            chk($sformatf("v%0d.dest", i), destino_atual, tab[i].e_dest);
            chk($sformatf("v%0d.eh", i), eh_origem, tab[i].e_eh);
            chk($sformatf("v%0d.sobe", i), sobe, tab[i].e_sobe);
            chk($sformatf("v%0d.cheg", i), chegouDestino, tab[i].e_cheg);
            chk($sformatf("v%0d.ocup", i), ocupacao, tab[i].e_ocup);
            chk($sformatf("v%0d.ready", i), pedido_ready, tab[i].e_ready);
            chk($sformatf("v%0d.inv", i), pedido_invalido, tab[i].e_inv);
            chk($sformatf("v%0d.est", i), db_estado, tab[i].e_est);
        end
        pedido_valid = 1'b0;
        shift        = 1'b0;
        andar_atual  = 2'd0;

        // fill to capacity
        pedido(0, 1);
        pedido(1, 2);
        pedido(2, 3);
        pedido(3, 0);
        chk("full.ocup", ocupacao, 8);
        chk("full.ready", pedido_ready, 0);
        shift = 1'b1;
        step();
        chk("pop1.ocup", ocupacao, 7);
        chk("pop1.ready", pedido_ready, 0);
        step();
        shift = 1'b0;
        chk("pop2.ocup", ocupacao, 6);
        chk("pop2.ready", pedido_ready, 1);
        chk_head("pop2", 1, 1, 1);

        // push and pop in the same cycle, across the pointer wrap
        pedido_origem  = 3;
        pedido_destino = 1;
        pedido_valid   = 1'b1;
        step();
        pedido_valid = 1'b0;
        shift        = 1'b1;
        chk("acc.estado", db_estado, 1);
        step();
        shift = 1'b0;
        chk("simul.ocup", ocupacao, 6);
        chk_head("simul", 1, 2, 0);
        step();
        chk("simul2.ocup", ocupacao, 7);
        for (int i = 0; i < 7; i++) begin
            chk_head($sformatf("drain%0d", i), 1, exp_floor[i], exp_eh[i]);
            shift = 1'b1;
            step();
            shift = 1'b0;
        end
        chk("drain.ocup", ocupacao, 0);
        chk("drain.tem", temDestino, 0);

        // comparators against current floor
        pedido(1, 2);
        andar_atual = 2'd3;
        #1;
        chk("cmp3.sobe", sobe, 0);
        chk("cmp3.cheg", chegouDestino, 0);
        andar_atual = 2'd1;
        #1;
        chk("cmp1.sobe", sobe, 0);
        chk("cmp1.cheg", chegouDestino, 1);
        andar_atual = 2'd0;
        #1;
        chk("cmp0.sobe", sobe, 1);
        chk("cmp0.cheg", chegouDestino, 0);

        // reset while writing the drop-off stop
        pedido_origem  = 0;
        pedido_destino = 2;
        pedido_valid   = 1'b1;
        step();
        pedido_valid = 1'b0;
        step();
        chk("mid.estado", db_estado, 2);
        reset = 1'b0;
        #1;
        chk("arst.tem", temDestino, 0);
        chk("arst.dest", destino_atual, 0);
        chk("arst.eh", eh_origem, 0);
        chk("arst.sobe", sobe, 0);
        chk("arst.ocup", ocupacao, 0);
        chk("arst.estado", db_estado, 0);
        chk("arst.ready", pedido_ready, 1);
        #3 reset = 1'b1;
        step();
        chk("post.ocup", ocupacao, 0);
        chk("post.estado", db_estado, 0);

        shift = 1'b1;
        step();
        shift = 1'b0;
        chk("emptypop.ocup", ocupacao, 0);
        chk("emptypop.tem", temDestino, 0);
        chk("emptypop.estado", db_estado, 0);

        // synchronous clear with three stops stored
        pedido(0, 1);
        pedido(2, 3);
        shift = 1'b1;
        step();
        shift = 1'b0;
        chk("pre_clr.ocup", ocupacao, 3);
        chk_head("pre_clr", 1, 1, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr.tem", temDestino, 0);
        chk("clr.ocup", ocupacao, 0);
        chk("clr.ready", pedido_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
